instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_imm_type_decoder.sv | 20 ++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// RISC-V opcodes that carry an I/S-type immediate, and immediate-select codes.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } fetch_state_t;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;

   localparam logic [2:0] IMM_I_ALU   = 3'b100;
   localparam logic [2:0] IMM_I_LOAD  = 3'b010;
   localparam logic [2:0] IMM_S_STORE = 3'b001;
   localparam logic [2:0] IMM_NONE    = 3'b000;

endpackage

// File: rtl/instr_fetch_unit_imm_type_decoder.sv
// Maps the held instruction's opcode to the immediate-type select used by
// the downstream sign-extension stage.
module imm_type_decoder
   import instr_fetch_unit_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [2:0] imm_cntrl
);

   always_comb begin
      imm_cntrl = IMM_NONE;
      case (opcode)
         OP_IMM, JALR: imm_cntrl = IMM_I_ALU;
         LOAD:         imm_cntrl = IMM_I_LOAD;
         STORE:        imm_cntrl = IMM_S_STORE;
         default:      imm_cntrl = IMM_NONE;
      endcase
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding-request instruction fetcher with redirect handling and a
// one-entry hold register toward decode.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                     WORD_LENGTH = 32,
   parameter logic [WORD_LENGTH-1:0] RESET_PC    = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req,
   output logic [WORD_LENGTH-1:0] imem_addr,
   input  logic                   imem_valid,
   input  logic [31:0]            imem_rdata,
   input  logic                   redirect_en,
   input  logic [WORD_LENGTH-1:0] redirect_pc,
   input  logic                   stall,
   output logic                   instr_valid,
   output logic [31:0]            instr_out,
   output logic [24:0]            instr_part,
   output logic [2:0]             imm_cntrl,
   output logic [WORD_LENGTH-1:0] pc_out
);

   localparam logic [WORD_LENGTH-1:0] PC_STEP = WORD_LENGTH'(4);

   fetch_state_t           r_state;
   logic [WORD_LENGTH-1:0] r_pc_reg;
   logic [WORD_LENGTH-1:0] r_fetch_addr;
   logic [WORD_LENGTH-1:0] r_pc_out;
   logic [31:0]            r_instr;
   logic                   r_instr_valid;
   logic                   r_imem_req;
   logic [WORD_LENGTH-1:0] w_redirect_target;

   assign w_redirect_target = {redirect_pc[WORD_LENGTH-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_pc_reg      <= RESET_PC;
         r_fetch_addr  <= RESET_PC;
         r_pc_out      <= RESET_PC;
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
         r_imem_req    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (redirect_en) begin
                  r_pc_reg     <= w_redirect_target;
                  r_fetch_addr <= w_redirect_target;
               end
               r_imem_req <= 1'b1;
               r_state    <= ST_FETCH;
            end
            ST_FETCH: begin
               if (redirect_en && imem_valid) begin
                  r_pc_reg     <= w_redirect_target;
                  r_fetch_addr <= w_redirect_target;
               end else if (redirect_en) begin
                  // Request already in flight: remember the target, let it drain.
                  r_pc_reg <= w_redirect_target;
                  r_state  <= ST_DRAIN;
               end else if (imem_valid) begin
                  r_instr       <= imem_rdata;
                  r_pc_out      <= r_fetch_addr;
                  r_pc_reg      <= r_fetch_addr + PC_STEP;
                  r_instr_valid <= 1'b1;
                  r_imem_req    <= 1'b0;
                  r_state       <= ST_HOLD;
               end
            end
            ST_DRAIN: begin
               if (imem_valid) begin
                  r_fetch_addr <= redirect_en ? w_redirect_target : r_pc_reg;
                  r_state      <= ST_FETCH;
               end
               if (redirect_en) begin
                  r_pc_reg <= w_redirect_target;
               end
            end
            ST_HOLD: begin
               if (redirect_en) begin
                  r_pc_reg      <= w_redirect_target;
                  r_fetch_addr  <= w_redirect_target;
                  r_instr_valid <= 1'b0;
                  r_imem_req    <= 1'b1;
                  r_state       <= ST_FETCH;
               end else if (!stall) begin
                  r_fetch_addr  <= r_pc_reg;
                  r_instr_valid <= 1'b0;
                  r_imem_req    <= 1'b1;
                  r_state       <= ST_FETCH;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_imem_req <= 1'b0;
            end
         endcase
      end
   end

   imm_type_decoder u_imm_type_decoder (
      .opcode    (r_instr[6:0]),
      .imm_cntrl (imm_cntrl)
   );

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_fetch_addr;
   assign instr_valid = r_instr_valid;
   assign instr_out   = r_instr;
   assign instr_part  = r_instr[31:7];
   assign pc_out      = r_pc_out;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: reset, fetch/hold, stall, redirects,
// address wrap and immediate-type decode.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [24:0] instr_part;
   logic [2:0]  imm_cntrl;
   logic [31:0] pc_out;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(.WORD_LENGTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_rdata  (imem_rdata),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .instr_part  (instr_part),
      .imm_cntrl   (imm_cntrl),
      .pc_out      (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
      redirect_en = 1'b0; redirect_pc = '0; stall = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc_out got=%h exp=0", pc_out); end
      checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instr_out); end
      tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL idle_to_fetch_req got=%b exp=1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL idle_to_fetch_addr got=%h exp=0", imem_addr); end
   endtask

   task automatic test_basic_fetch();
      do_reset();
      tick();
      imem_valid = 1'b1; imem_rdata = 32'h0050_0093;
      tick();
      imem_valid = 1'b0;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", instr_valid); end
      checks++; if (imm_cntrl !== 3'b100) begin errors++; $display("FAIL basic_imm got=%b exp=100", imm_cntrl); end
      checks++; if (instr_part !== 25'h000A001) begin errors++; $display("FAIL basic_part got=%h exp=000a001", instr_part); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL basic_pc_out got=%h exp=0", pc_out); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_hold_req got=%b exp=0", imem_req); end
      tick();
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr got=%h exp=4", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got=%b exp=0", instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_next_req got=%b exp=1", imem_req); end
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      imem_valid = 1'b1; imem_rdata = 32'h0000_2103; stall = 1'b1;
      tick();
      imem_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, instr_valid); end
         checks++; if (instr_out !== 32'h0000_2103) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=00002103", i, instr_out); end
         checks++; if (imm_cntrl !== 3'b010) begin errors++; $display("FAIL stall_imm[%0d] got=%b exp=010", i, imm_cntrl); end
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got=%b exp=0", i, imem_req); end
         tick();
      end
      stall = 1'b0;
      tick();
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL stall_next_addr got=%h exp=4", imem_addr); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_next_req got=%b exp=1", imem_req); end
   endtask

   task automatic test_redirect_drain();
      do_reset();
      tick();
      redirect_en = 1'b1; redirect_pc = 32'h0000_0102;
      tick();
      redirect_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drain_req[%0d] got=%b exp=1", i, imem_req); end
         checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL drain_addr[%0d] got=%h exp=0", i, imem_addr); end
         checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL drain_valid[%0d] got=%b exp=0", i, instr_valid); end
         tick();
      end
      imem_valid = 1'b1; imem_rdata = 32'h0050_0093;
      tick();
      imem_valid = 1'b0;
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL drain_new_addr got=%h exp=100", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL drain_discard got=%b exp=0", instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drain_new_req got=%b exp=1", imem_req); end
   endtask

   task automatic test_redirect_same_cycle();
      do_reset();
      tick();
      redirect_en = 1'b1; redirect_pc = 32'h0000_020B;
      imem_valid = 1'b1; imem_rdata = 32'h0000_2103;
      tick();
      redirect_en = 1'b0; imem_valid = 1'b0;
      checks++; if (imem_addr !== 32'h208) begin errors++; $display("FAIL same_addr got=%h exp=208", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL same_valid got=%b exp=0", instr_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL same_req got=%b exp=1", imem_req); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL same_valid_later got=%b exp=0", instr_valid); end
   endtask

   task automatic test_wrap_store();
      do_reset();
      tick();
      redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_valid = 1'b1;
      tick();
      redirect_en = 1'b0;
      imem_rdata = 32'h00A1_2023;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch_addr got=%h exp=fffffffc", imem_addr); end
      tick();
      imem_valid = 1'b0;
      checks++; if (imm_cntrl !== 3'b001) begin errors++; $display("FAIL wrap_imm got=%b exp=001", imm_cntrl); end
      checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_out got=%h exp=fffffffc", pc_out); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", instr_valid); end
      tick();
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got=%h exp=0", imem_addr); end
   endtask

   task automatic test_redirect_in_hold();
      do_reset();
      tick();
      imem_valid = 1'b1; imem_rdata = 32'h0000_0067; stall = 1'b1;
      tick();
      imem_valid = 1'b0;
      checks++; if (imm_cntrl !== 3'b100) begin errors++; $display("FAIL jalr_imm got=%b exp=100", imm_cntrl); end
      redirect_en = 1'b1; redirect_pc = 32'h0000_0031;
      tick();
      redirect_en = 1'b0; stall = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL hold_redir_valid got=%b exp=0", instr_valid); end
      checks++; if (imem_addr !== 32'h30) begin errors++; $display("FAIL hold_redir_addr got=%h exp=30", imem_addr); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hold_redir_req got=%b exp=1", imem_req); end
      imem_valid = 1'b1; imem_rdata = 32'h0020_80B3;
      tick();
      imem_valid = 1'b0;
      checks++; if (imm_cntrl !== 3'b000) begin errors++; $display("FAIL rtype_imm got=%b exp=000", imm_cntrl); end
      checks++; if (pc_out !== 32'h30) begin errors++; $display("FAIL hold_redir_pc_out got=%h exp=30", pc_out); end
   endtask

   task automatic test_reset_in_hold();
      do_reset();
      tick();
      imem_valid = 1'b1; imem_rdata = 32'h0000_2103; stall = 1'b1;
      tick();
      imem_valid = 1'b0;
      rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h0000_0040;
      tick();
      rst = 1'b0; redirect_en = 1'b0; stall = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rsthold_valid got=%b exp=0", instr_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rsthold_req got=%b exp=0", imem_req); end
      checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL rsthold_instr got=%h exp=0", instr_out); end
      imem_valid = 1'b1;
      tick();
      imem_valid = 1'b0;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rsthold_fetch_req got=%b exp=1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rsthold_fetch_addr got=%h exp=0", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rsthold_stray got=%b exp=0", instr_valid); end
   endtask

   initial begin
      rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
      redirect_en = 1'b0; redirect_pc = '0; stall = 1'b0;
      test_reset();
      test_basic_fetch();
      test_stall();
      test_redirect_drain();
      test_redirect_same_cycle();
      test_wrap_store();
      test_redirect_in_hold();
      test_reset_in_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
